// File: rtl/vcr_digit_display_if.sv
// Key input and display output bundle for vcr_digit_display.
// master: the key decoder / display consumer side.
// slave : the digit display block itself.
interface vcr_digit_display_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] entry_count;
  logic       entry_full;

  modport master (
    output key_valid,
    output key_code,
    input  seg,
    input  an,
    input  entry_count,
    input  entry_full
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output seg,
    output an,
    output entry_count,
    output entry_full
  );
endinterface

// File: rtl/vcr_digit_display.sv
// VCR remote-entry 4-digit display.
// Accepts one decoded key per key_valid assertion into a 4-digit shift
// buffer and multiplexes the digits onto a common 7-segment bus.
// Optional feature macro: IDLE_BLANK_EN -- when defined, the entry is
// auto-cleared after BLANK_TIMEOUT idle cycles with a non-empty buffer.
module vcr_digit_display #(
  parameter int SCAN_DIV      = 25,
  parameter int BLANK_TIMEOUT = 50000
) (
  input logic                 clk_10KHz,
  input logic                 reset,
  vcr_digit_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    WAIT = 1'b0,
    HOLD = 1'b1
  } key_state_e;

  key_state_e       key_state_r;
  logic [3:0]       digit_r [0:3];
  logic [2:0]       count_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       index_r;
  logic             accept_s;

  // Active-low segment pattern for one decimal digit (abc_defg).
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b100_0000;
      4'd1:    s = 7'b111_1001;
      4'd2:    s = 7'b010_0100;
      4'd3:    s = 7'b011_0000;
      4'd4:    s = 7'b001_1001;
      4'd5:    s = 7'b001_0010;
      4'd6:    s = 7'b000_0010;
      4'd7:    s = 7'b111_1000;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b001_1000;
      default: s = 7'b111_1111;
    endcase
    return s;
  endfunction

  // A key is taken only when the FSM is waiting for a fresh press.
  always_comb begin
    accept_s = (key_state_r == WAIT) && bus.key_valid;
  end

`ifdef IDLE_BLANK_EN
  localparam int TMR_W = (BLANK_TIMEOUT > 1) ? $clog2(BLANK_TIMEOUT) : 1;

  logic [TMR_W-1:0] timer_r;
  logic             timeout_s;

  // Idle timer expiry; the timer never runs past BLANK_TIMEOUT-1.
  always_comb begin
    timeout_s = (timer_r == TMR_W'(BLANK_TIMEOUT - 1));
  end
`endif

  // Key FSM, digit buffer, entry count and (optionally) idle timer.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      key_state_r <= WAIT;
      count_r     <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        digit_r[i] <= 4'd0;
      end
`ifdef IDLE_BLANK_EN
      timer_r     <= '0;
`endif
    end else begin
      case (key_state_r)
        WAIT:    if (bus.key_valid)  key_state_r <= HOLD;
        HOLD:    if (!bus.key_valid) key_state_r <= WAIT;
        default: key_state_r <= WAIT;
      endcase

      if (accept_s) begin
        if (bus.key_code <= 4'd9) begin
          // New digit enters on the right; the oldest falls off when full.
          digit_r[3] <= digit_r[2];
          digit_r[2] <= digit_r[1];
          digit_r[1] <= digit_r[0];
          digit_r[0] <= bus.key_code;
          count_r    <= (count_r == 3'd4) ? 3'd4 : count_r + 3'd1;
        end else if (bus.key_code == 4'd10) begin
          count_r <= 3'd0;
        end else if ((bus.key_code == 4'd11) && (count_r != 3'd0)) begin
          digit_r[0] <= digit_r[1];
          digit_r[1] <= digit_r[2];
          digit_r[2] <= digit_r[3];
          digit_r[3] <= 4'd0;
          count_r    <= count_r - 3'd1;
        end
      end
`ifdef IDLE_BLANK_EN
      else if (timeout_s) begin
        count_r <= 3'd0;
      end

      if (accept_s || (count_r == 3'd0) || timeout_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TMR_W'(1);
      end
`endif
    end
  end

  // Digit scan: SCAN_DIV clocks per digit, index walks 0..3.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      div_r   <= '0;
      index_r <= 2'd0;
    end else if (div_r == DIV_W'(SCAN_DIV - 1)) begin
      div_r   <= '0;
      index_r <= index_r + 2'd1;
    end else begin
      div_r   <= div_r + DIV_W'(1);
    end
  end

  // Display drive from registered state only; unused positions blanked.
  always_comb begin
    bus.an          = ~(4'b0001 << index_r);
    bus.entry_count = count_r;
    bus.entry_full  = (count_r == 3'd4);
    if ({1'b0, index_r} < count_r) begin
      bus.seg = decode_digit(digit_r[index_r]);
    end else begin
      bus.seg = 7'b111_1111;
    end
  end

endmodule

// File: tb/tb_vcr_digit_display.sv
// Self-checking bench for vcr_digit_display.
// Reference model: the entered number as a queue of digits (newest first),
// a scan position derived from elapsed cycles, and (with IDLE_BLANK_EN)
// the edge number of the last accepted key.
module tb_vcr_digit_display;

  localparam int SD = 25;
  localparam int BT = 100;

  logic clk_10KHz = 1'b0;
  logic reset;

  vcr_digit_display_if bus ();

  vcr_digit_display #(
    .SCAN_DIV      (SD),
    .BLANK_TIMEOUT (BT)
  ) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  logic [6:0] seg_tab [10] = '{7'b100_0000, 7'b111_1001, 7'b010_0100,
                               7'b011_0000, 7'b001_1001, 7'b001_0010,
                               7'b000_0010, 7'b111_1000, 7'b000_0000,
                               7'b001_1000};

  int n_asserts = 0;
  int n_fail    = 0;

  // model state
  int q[$];
  bit holding  = 1'b0;
  int n_scan   = 0;
  int edge_no  = 0;
  int last_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_key(input int code);
    if (code <= 9) begin
      q.push_front(code);
      if (q.size() > 4) void'(q.pop_back());
    end else if (code == 10) begin
      q.delete();
    end else if (code == 11) begin
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    int         idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk_10KHz);
    edge_no++;
    if (reset) begin
      q.delete();
      holding = 1'b0;
      n_scan  = 0;
    end else begin
      if (!holding && bus.key_valid) begin
        apply_key(int'(bus.key_code));
        holding  = 1'b1;
        last_acc = edge_no;
      end else begin
        if (!bus.key_valid) holding = 1'b0;
`ifdef IDLE_BLANK_EN
        if ((q.size() > 0) && (edge_no - last_acc == BT)) q.delete();
`endif
      end
      n_scan++;
    end
    @(negedge clk_10KHz);
    idx   = (n_scan / SD) % 4;
    e_an  = ~(4'b0001 << idx);
    e_seg = (idx < q.size()) ? seg_tab[q[idx]] : 7'b111_1111;
    check_eq("entry_count", {29'd0, bus.entry_count}, q.size());
    check_eq("entry_full", {31'd0, bus.entry_full}, {31'd0, q.size() == 4});
    check_eq("an", {28'd0, bus.an}, {28'd0, e_an});
    check_eq("seg", {25'd0, bus.seg}, {25'd0, e_seg});
  endtask

  task automatic press(input int c, input int hold, input int gap);
    bus.key_code  = c[3:0];
    bus.key_valid = 1'b1;
    repeat (hold) tick();
    bus.key_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Walk a full refresh and check each position against the expected digits.
  task automatic scan_digits(input int nd, input int e0, input int e1,
                             input int e2, input int e3);
    int ed[4];
    int idx;
    ed = '{e0, e1, e2, e3};
    repeat (4 * SD) begin
      tick();
      case (bus.an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) check_eq("scan_an_onehot", {28'd0, bus.an}, 32'hE);
      else if (idx < nd) check_eq("scan_digit", {25'd0, bus.seg}, {25'd0, seg_tab[ed[idx]]});
      else check_eq("scan_blank", {25'd0, bus.seg}, 32'h7F);
    end
  endtask

  initial begin
    logic [3:0] prev_an;
    int         run_len;
    int         n_trans;

    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    repeat (3) tick();
    check_eq("rst_an", {28'd0, bus.an}, 32'hE);
    check_eq("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check_eq("rst_count", {29'd0, bus.entry_count}, 32'd0);
    check_eq("rst_full", {31'd0, bus.entry_full}, 32'd0);
    reset = 1'b0;

    // long hold of one key: exactly one accept
    press(7, 200, 1);
    check_eq("hold200_count", {29'd0, bus.entry_count}, 32'd1);
    scan_digits(1, 7, 0, 0, 0);

    // overflow: 1..5 keeps the last four
    press(10, 1, 1);
    for (int k = 1; k <= 5; k++) press(k, 2, 1);
    check_eq("full_count", {29'd0, bus.entry_count}, 32'd4);
    check_eq("full_flag", {31'd0, bus.entry_full}, 32'd1);
    scan_digits(4, 5, 4, 3, 2);

    // backspace without underflow
    press(10, 1, 1);
    press(1, 1, 1);
    press(2, 1, 1);
    check_eq("bs_start", {29'd0, bus.entry_count}, 32'd2);
    press(11, 1, 1);
    check_eq("bs_1", {29'd0, bus.entry_count}, 32'd1);
    press(11, 1, 1);
    check_eq("bs_0", {29'd0, bus.entry_count}, 32'd0);
    press(11, 1, 1);
    check_eq("bs_underflow", {29'd0, bus.entry_count}, 32'd0);

    // scan pattern with a single "9"
    press(9, 1, 1);
    prev_an = bus.an;
    run_len = 0;
    n_trans = 0;
    repeat (6 * SD) begin
      tick();
      run_len++;
      if (bus.an == 4'b1110) check_eq("scan9_seg", {25'd0, bus.seg}, 32'h18);
      else check_eq("scan9_blank", {25'd0, bus.seg}, 32'h7F);
      if (bus.an != prev_an) begin
        if (n_trans > 0) check_eq("scan_period", run_len, SD);
        n_trans++;
        run_len = 0;
        prev_an = bus.an;
      end
    end
    check_eq("scan_transitions", n_trans, 6);

`ifdef IDLE_BLANK_EN
    // idle blank exactly BT cycles after accept
    press(10, 1, 1);
    press(3, 1, 0);
    bus.key_valid = 1'b0;
    repeat (BT - 1) tick();
    check_eq("idle_before", {29'd0, bus.entry_count}, 32'd1);
    tick();
    check_eq("idle_expired", {29'd0, bus.entry_count}, 32'd0);
    // key accepted on the expiry edge wins
    press(3, 1, 0);
    repeat (BT - 1) tick();
    press(8, 1, 1);
    check_eq("idle_key_wins", {29'd0, bus.entry_count}, 32'd2);
`endif

    // reset in the middle of a held key
    press(10, 1, 1);
    press(1, 1, 1);
    press(2, 1, 1);
    bus.key_code  = 4'd3;
    bus.key_valid = 1'b1;
    repeat (3) tick();
    check_eq("hold_count3", {29'd0, bus.entry_count}, 32'd3);
    reset = 1'b1;
    tick();
    check_eq("midrst_count", {29'd0, bus.entry_count}, 32'd0);
    check_eq("midrst_an", {28'd0, bus.an}, 32'hE);
    reset = 1'b0;
    tick();
    check_eq("post_rst_accept", {29'd0, bus.entry_count}, 32'd1);
    repeat (5) tick();
    check_eq("post_rst_once", {29'd0, bus.entry_count}, 32'd1);
    bus.key_valid = 1'b0;
    tick();

    // randomized key traffic against the model
    repeat (300) begin
      int c;
      int h;
      int g;
      c = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) c = $urandom_range(0, 9);
      h = $urandom_range(1, 4);
      g = $urandom_range(0, 3);
`ifdef IDLE_BLANK_EN
      if ($urandom_range(0, 19) == 0) g = $urandom_range(BT - 12, BT + 10);
`endif
      press(c, h, g);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    bus.key_valid = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/vcr_digit_display.md
VCR_DIGIT_DISPLAY -- requirements
Module: vcr_digit_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 25: clk_10KHz cycles per displayed digit (100 Hz full refresh).
REQ-002 The block SHALL have parameter BLANK_TIMEOUT, default 50000: idle cycles before auto-clear (5 s).
REQ-003 The block SHALL have port clk_10KHz  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port key_valid  input  1  level from the VCR decoder; high while a decoded key is presented (may stay high many cycles).
REQ-006 The block SHALL have port key_code  input  4  decoded key: 0-9 digit, 10 clear, 11 backspace, 12-15 ignored.
REQ-007 The block SHALL have port seg  output  7  active-low segments, abc_defg order, for the digit selected by an.
REQ-008 The block SHALL have port an  output  4  active-low one-hot digit enable; an[0] = rightmost digit.
REQ-009 The block SHALL have port entry_count  output  3  number of entered digits, 0-4.
REQ-010 The block SHALL have port entry_full  output  1  high when entry_count == 4.

Function
REQ-011 The key FSM SHALL have states WAIT and HOLD, and SHALL accept a key only in WAIT on a cycle where key_valid is sampled high, then move to HOLD.
REQ-012 In HOLD, the key FSM SHALL ignore key_code and SHALL return to WAIT on the first cycle key_valid is sampled low, so one key is accepted per key_valid assertion.
REQ-013 Buffer updates SHALL occur on the same clock edge that accepts the key, and entry_count/entry_full SHALL reflect them the following cycle.
REQ-014 A digit key SHALL shift d0->d1->d2->d3 and load key_code into d0; count SHALL increment, saturating at 4; when count is 4, d3 SHALL be discarded.
REQ-015 Key 10 (clear) SHALL set count to 0; digit registers need not be cleared.
REQ-016 Key 11 (backspace) SHALL shift d3->d2->d1->d0 and decrement count; it SHALL be a no-op when count is 0.
REQ-017 Keys 12-15 SHALL be accepted by the FSM, entering HOLD, but SHALL leave the buffer unchanged.
REQ-018 The scan divider SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL equal ~(1 << index).
REQ-020 seg SHALL be the decode of d[index] when index < count, and SHALL be 7'b111_1111 otherwise (leading blanks).
REQ-021 The digit decode SHALL be: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_1000.
REQ-022 seg and an SHALL be combinational from registered index, count and digits only, with no path from key inputs.

Reset
REQ-023 While reset is high at a clock edge, the block SHALL set FSM=WAIT, count=0, digits=0, scan divider=0, index=0, and blank timer=0.
REQ-024 During and immediately after reset, outputs SHALL be an=4'b1110, seg=7'b111_1111, entry_count=0, entry_full=0.
REQ-025 Reset SHALL override any simultaneous key or timer event.
REQ-026 If key_valid is high when reset releases, that key SHALL be accepted on the first non-reset edge.

Configuration
REQ-027 With IDLE_BLANK_EN defined, a blank timer SHALL increment every cycle the FSM accepts no key and count > 0, and SHALL reset to 0 on any accepted key or when count is 0.
REQ-028 With IDLE_BLANK_EN defined, when the blank timer reaches BLANK_TIMEOUT-1, count SHALL be set to 0 on that edge.
REQ-029 With IDLE_BLANK_EN defined, a key accepted on the same edge as timeout SHALL win: the key SHALL apply to the old buffer and the timer SHALL reset.
REQ-030 Without IDLE_BLANK_EN, no timer logic SHALL exist and entries SHALL persist indefinitely.

Verification
REQ-031 The bench SHALL check: reset, then key_valid held 200 cycles with code 7 -> count=1, d0=7, exactly one accept.
REQ-032 The bench SHALL check: keys 1,2,3,4,5 -> count=4, entry_full=1, digits d3..d0 = 2,3,4,5.
REQ-033 The bench SHALL check: buffer "12", then backspace, backspace, backspace -> count 1, 0, 0, with no underflow.
REQ-034 The bench SHALL check: buffer "9" with SCAN_DIV=25 -> an cycles 1110,1101,1011,0111 every 25 cycles; seg=001_1000 only while an=1110, 111_1111 otherwise.
REQ-035 The bench SHALL check, with IDLE_BLANK_EN and BLANK_TIMEOUT=100: key 3 then idle -> count=0 exactly 100 cycles after accept; a key on the expiry cycle -> count=2.
REQ-036 The bench SHALL check: reset asserted mid-HOLD with count=3 -> count=0 and an=1110 the next cycle; key_valid still high after release -> accepted once.
